// File: rtl/sched_pkg.sv
// Types and defaults shared between the VOQ blocks and the crossbar scheduler.
package sched_pkg;
  localparam int NUM_PORTS      = 4;
  localparam int SLOT_WORDS_DEF = 4;

  typedef logic [1:0] voq_idx_t;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} voq_state_e;
endpackage

// File: rtl/voq_fifo.sv
// Single-clock FIFO of {eop, data} words with registered read.
// The head word's top bit is exposed so the reader knows a word is the packet tail before reading it.
module voq_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_head_msb,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic [W-1:0] r_rd_data;
  logic         w_wr, w_rd;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty    = (r_wptr == r_rptr);
  assign o_head_msb = r_mem[r_rptr[AW-1:0]][W-1];
  assign o_rd_data  = r_rd_data;
  assign w_wr       = i_wr_en && !o_full;
  assign w_rd       = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rd_data <= r_mem[r_rptr[AW-1:0]];
        r_rptr    <= r_rptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ingress_voq.sv
// Per-ingress virtual output queues feeding the crossbar scheduler, one slot of words per grant.
// Define INGRESS_STATS_EN to add per-VOQ sent-packet and ignored-grant counters.
module ingress_voq
  import sched_pkg::*;
#(
  parameter int NUM_VOQ    = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_W     = 32,
  parameter int SLOT_WORDS = SLOT_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              in_eop,
  input  logic              grant_en,
  input  logic [1:0]        grant_voq,
  output logic [NUM_VOQ-1:0] voq_empty,
  output logic              is_busy,
  output logic [1:0]        busy_voq,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eop,
  output logic [1:0]        out_voq
`ifdef INGRESS_STATS_EN
  ,
  output logic [NUM_VOQ*16-1:0] pkt_sent_cnt,
  output logic [7:0]        bad_grant_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(SLOT_WORDS + 1);

  logic                         r_in_pkt;
  voq_idx_t                     r_cur_dest, w_dest, r_sel, w_rd_voq, r_busy_voq, r_out_voq;
  logic                         w_wr, w_rd_en, w_rd_eop, w_last, w_grant_ok;
  logic                         r_busy, r_out_valid;
  logic [SW-1:0]                r_slot_cnt;
  voq_state_e                   r_state, w_state_nxt;
  logic [NUM_VOQ-1:0]           w_full, w_empty, w_head_eop;
  logic [NUM_VOQ-1:0][DATA_W:0] w_rd_data;

  // Destination is held from the first word until the word after EOP.
  assign w_dest   = r_in_pkt ? r_cur_dest : in_dest;
  assign in_ready = !w_full[w_dest];
  assign w_wr     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_pkt   <= 1'b0;
      r_cur_dest <= '0;
    end else if (w_wr) begin
      r_in_pkt   <= !in_eop;
      r_cur_dest <= w_dest;
    end
  end

  assign w_grant_ok = grant_en && (r_state == IDLE) && !voq_empty[grant_voq] &&
                      !w_empty[grant_voq] && (!r_busy || (grant_voq == r_busy_voq));

  // The grant cycle itself issues the first read so data appears one cycle after the grant.
  always_comb begin
    w_rd_en  = 1'b0;
    w_rd_voq = r_sel;
    if (r_state == SEND) begin
      w_rd_en = 1'b1;
    end else if (w_grant_ok) begin
      w_rd_en  = 1'b1;
      w_rd_voq = grant_voq;
    end
  end

  assign w_rd_eop = w_rd_en && w_head_eop[w_rd_voq];
  assign w_last   = w_rd_en && !w_rd_eop &&
                    ((r_state == SEND) ? (r_slot_cnt == SW'(1)) : (SLOT_WORDS == 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_ok && !w_rd_eop && !w_last) w_state_nxt = SEND;
      SEND:    if (w_rd_eop || w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_slot_cnt counts words still allowed in this slot, including the one read this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_slot_cnt  <= '0;
      r_busy      <= 1'b0;
      r_busy_voq  <= '0;
      r_out_valid <= 1'b0;
      r_out_voq   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_rd_en;
      r_out_voq   <= w_rd_en ? w_rd_voq : voq_idx_t'(0);
      if (r_state == IDLE && w_grant_ok) begin
        r_sel      <= grant_voq;
        r_slot_cnt <= SW'(SLOT_WORDS - 1);
      end else if (r_state == SEND) begin
        r_slot_cnt <= r_slot_cnt - 1'b1;
      end
      if (w_rd_eop) begin
        r_busy <= 1'b0;
      end else if (w_last) begin
        r_busy     <= 1'b1;
        r_busy_voq <= w_rd_voq;
      end
    end
  end

  assign is_busy   = r_busy;
  assign busy_voq  = r_busy_voq;
  assign out_valid = r_out_valid;
  assign out_voq   = r_out_voq;
  assign out_data  = r_out_valid ? w_rd_data[r_out_voq][DATA_W-1:0] : '0;
  assign out_eop   = r_out_valid && w_rd_data[r_out_voq][DATA_W];

  for (genvar i = 0; i < NUM_VOQ; i++) begin : g_voq
    logic          w_inc, w_dec, r_emp;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    assign w_inc     = w_wr && in_eop && (w_dest == voq_idx_t'(i));
    assign w_dec     = w_rd_eop && (w_rd_voq == voq_idx_t'(i));
    assign w_cnt_nxt = r_cnt + CW'(w_inc) - CW'(w_dec);
    assign voq_empty[i] = r_emp;

    voq_fifo #(.DEPTH(DEPTH), .W(DATA_W + 1)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_wr && (w_dest == voq_idx_t'(i))),
      .i_wr_data  ({in_eop, in_data}),
      .i_rd_en    (w_rd_en && (w_rd_voq == voq_idx_t'(i))),
      .o_rd_data  (w_rd_data[i]),
      .o_head_msb (w_head_eop[i]),
      .o_full     (w_full[i]),
      .o_empty    (w_empty[i])
    );

    // Empty flag tracks the next count so it flips the cycle after the EOP write/read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_emp <= 1'b1;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_emp <= (w_cnt_nxt == '0);
      end
    end

`ifdef INGRESS_STATS_EN
    logic [15:0] r_sent;
    assign pkt_sent_cnt[i*16 +: 16] = r_sent;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_sent <= '0;
      else if (w_dec) r_sent <= r_sent + 1'b1;
    end
`endif
  end

`ifdef INGRESS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           bad_grant_cnt <= '0;
    else if (grant_en && !w_grant_ok && bad_grant_cnt != 8'hff) bad_grant_cnt <= bad_grant_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ingress_voq.sv
// Bench for ingress_voq: directed scenarios plus random traffic against a queue-level reference model.
module tb_ingress_voq;
  localparam int DEPTH = 16;
  localparam int SLOT  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_eop, grant_en;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_dest, grant_voq, busy_voq, out_voq;
  logic [3:0]  voq_empty;
  logic        is_busy, out_valid, out_eop;
`ifdef INGRESS_STATS_EN
  logic [63:0] pkt_sent_cnt;
  logic [7:0]  bad_grant_cnt;
`endif

  ingress_voq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_eop(in_eop), .grant_en(grant_en), .grant_voq(grant_voq),
    .voq_empty(voq_empty), .is_busy(is_busy), .busy_voq(busy_voq), .out_valid(out_valid),
    .out_data(out_data), .out_eop(out_eop), .out_voq(out_voq)
`ifdef INGRESS_STATS_EN
    , .pkt_sent_cnt(pkt_sent_cnt), .bad_grant_cnt(bad_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per-VOQ word queues; a VOQ is schedulable when it holds an EOP word.
  logic [32:0] m_q [4][$];
  int m_rem, m_sel, m_busy_voq, m_cur_dest, m_bad;
  bit m_busy, m_in_pkt;
  int m_sent [4];
  bit e_v, e_eop;
  int e_voq;
  logic [31:0] e_data;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit has_pkt(int v);
    for (int k = 0; k < m_q[v].size(); k++) if (m_q[v][k][32]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = !has_pkt(i);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i].delete();
      m_sent[i] = 0;
    end
    m_rem = 0; m_sel = 0; m_busy = 0; m_busy_voq = 0; m_in_pkt = 0; m_cur_dest = 0;
    m_bad = 0; e_v = 0; e_eop = 0; e_voq = 0; e_data = '0;
  endtask

  task automatic check_outs();
    chk("out_valid", out_valid, e_v);
    chk("out_voq", out_voq, e_v ? e_voq : 0);
    if (e_v) begin
      chk("out_data", out_data, e_data);
      chk("out_eop", out_eop, e_eop);
    end
    chk("is_busy", is_busy, m_busy);
    if (m_busy) chk("busy_voq", busy_voq, m_busy_voq);
    chk("voq_empty", voq_empty, exp_empty());
  endtask

  task automatic step(bit v, logic [31:0] d, int dest, bit eop, bit g, int gv);
    int dd;
    bit rdy;
    logic [32:0] w;
    @(negedge clk);
    in_valid = v; in_data = d; in_dest = 2'(dest); in_eop = eop;
    grant_en = g; grant_voq = 2'(gv);
    dd  = m_in_pkt ? m_cur_dest : dest;
    rdy = m_q[dd].size() < DEPTH;
    #1 chk("in_ready", in_ready, rdy);
    e_v = 0;
    if (g) begin
      if (m_rem == 0 && has_pkt(gv) && (!m_busy || gv == m_busy_voq)) begin
        m_sel = gv;
        m_rem = SLOT;
      end else if (m_bad < 255) m_bad++;
    end
    if (m_rem > 0) begin
      w = m_q[m_sel].pop_front();
      m_rem--;
      e_v = 1; e_voq = m_sel; e_data = w[31:0]; e_eop = w[32];
      if (e_eop) begin
        m_rem = 0; m_busy = 0; m_sent[m_sel]++;
      end else if (m_rem == 0) begin
        m_busy = 1; m_busy_voq = m_sel;
      end
    end
    if (v && rdy) begin
      m_q[dd].push_back({eop, d});
      m_in_pkt = !eop;
      m_cur_dest = dd;
    end
    @(posedge clk);
    #1 check_outs();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic send_pkt(int dest, int len);
    for (int i = 0; i < len; i++) step(1, $urandom, dest, i == len - 1, 0, 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = '0; in_dest = '0; in_eop = 0; grant_en = 0; grant_voq = '0;
    model_reset();
    #12;
    chk("rst_voq_empty", voq_empty, 4'hf);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_is_busy", is_busy, 0);
    chk("rst_out_voq", out_voq, 0);
    @(negedge clk); rst_n = 1;

    // 3-word packet to VOQ 2, then a full drain
    send_pkt(2, 3);
    chk("t1_empty", voq_empty, 4'b1011);
    step(0, '0, 0, 0, 1, 2);
    chk("t1_first_word", out_valid, 1);
    idle(3);
    chk("t1_drained", voq_empty, 4'hf);

    // 6-word packet to VOQ 1 spans two slots
    send_pkt(1, 6);
    step(0, '0, 0, 0, 1, 1);
    idle(3);
    chk("t2_busy", is_busy, 1);
    chk("t2_busy_voq", busy_voq, 1);
    step(0, '0, 0, 0, 1, 1);
    idle(2);
    chk("t2_not_busy", is_busy, 0);

    // Fill VOQ 0; its destination blocks while a new packet to VOQ 3 goes through
    send_pkt(0, 16);
    step(1, 32'h1234, 0, 1, 0, 0);
    chk("t3_full_block", in_ready, 0);
    step(1, 32'h3333, 3, 1, 0, 0);
    chk("t3_dest3_queued", voq_empty[3], 0);
    step(0, '0, 0, 0, 1, 3);
    idle(1);
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 0, 0, 1, 0);
      idle(4);
    end

    // Ignored grants: empty VOQ and wrong VOQ while busy
    send_pkt(0, 1);
    send_pkt(1, 6);
    step(0, '0, 0, 0, 1, 1);
    idle(4);
    step(0, '0, 0, 0, 1, 3);
    step(0, '0, 0, 0, 1, 0);
    chk("t4_no_out", out_valid, 0);
`ifdef INGRESS_STATS_EN
    chk("t4_bad_grant", bad_grant_cnt, 2);
`endif
    step(0, '0, 0, 0, 1, 1);
    idle(2);
    step(0, '0, 0, 0, 1, 0);
    idle(2);

    // Same-cycle enqueue EOP and dequeue EOP on VOQ 2
    send_pkt(2, 2);
    step(1, 32'haaaa, 2, 0, 1, 2);
    step(1, 32'hbbbb, 2, 1, 0, 0);
    chk("t5_eop_both", out_eop, 1);
    chk("t5_still_full", voq_empty[2], 0);
    step(0, '0, 0, 0, 1, 2);
    idle(3);

    // Asynchronous reset in the middle of a slot
    send_pkt(0, 4);
    step(0, '0, 0, 0, 1, 0);
    idle(1);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_empty", voq_empty, 4'hf);
    chk("t6_rst_busy", is_busy, 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    send_pkt(3, 2);
    step(0, '0, 0, 0, 1, 3);
    idle(2);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      int gv;
      gv = (m_busy && $urandom_range(3) != 0) ? m_busy_voq : $urandom_range(3);
      step($urandom_range(1), $urandom, $urandom_range(3), $urandom_range(2) == 0,
           $urandom_range(3) == 0, gv);
    end
`ifdef INGRESS_STATS_EN
    chk("stats_bad", bad_grant_cnt, m_bad);
    for (int i = 0; i < 4; i++) chk("stats_sent", pkt_sent_cnt[i*16 +: 16], m_sent[i] & 16'hffff);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
